sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the 8x16 FIFO.
//  Configurable width and depth, with:
//   - simultaneous read+write in the same cycle
//   - programmable almost-full / almost-empty flags
//   - occupancy output and synchronous flush
//   - overflow / underflow error pulses
//   - optional first-word-fall-through (FWFT) read mode
//  Sits between producer/consumer blocks as the standard buffering element.
// PARAMETERS
//  DATA_W  8          data width in bits (>=1)
//  DEPTH   16         number of entries; power of 2, >=2
//  AF_LVL  DEPTH-2    almost_full asserts when count >= AF_LVL
//  AE_LVL  2          almost_empty asserts when count <= AE_LVL
//  FWFT    0          0 = registered read (1-cycle latency); 1 = fall-through
// PORTS
//  clk           in   1           single clock; all logic on posedge
//  rst_n         in   1           asynchronous reset, active-low
//  clr           in   1           synchronous flush
//  wr            in   1           write request
//  din           in   DATA_W      write data
//  rd            in   1           read request (pop)
//  dout          out  DATA_W      read data
//  full          out  1           count == DEPTH
//  empty         out  1           count == 0
//  almost_full   out  1           count >= AF_LVL
//  almost_empty  out  1           count <= AE_LVL
//  count         out  AW+1        occupancy 0..DEPTH, where AW = $clog2(DEPTH)
//  overflow      out  1           1-cycle pulse: write rejected
//  underflow     out  1           1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset (rst_n=0, async): wptr=rptr=0, count=0, dout=0, overflow=underflow=0.
//    Flags follow from count: empty=1, almost_empty=1, full=0, almost_full=0.
//    Memory contents are not reset.
//  - Flags are combinational from count. count is registered.
//  - Pointers are AW bits and wrap naturally DEPTH-1 -> 0.
//  - Accept rules, evaluated each posedge with pre-edge state:
//    - rd_ok = rd & !empty
//    - wr_ok = wr & (!full | rd)
//    - Full with wr&rd: both accepted; count unchanged; write lands in the slot freed by the read.
//    - Empty with wr&rd: write accepted, read rejected (underflow=1), count -> 1.
//  - count_next = count + wr_ok - rd_ok. Never exceeds DEPTH and never goes below 0.
//  - overflow = wr & !wr_ok, registered, high for exactly one cycle. Same for underflow with rd & !rd_ok.
//  - FWFT=0:
//    - On rd_ok, dout <= mem[rptr] and appears the cycle after the rd edge.
//    - dout holds its value otherwise.
//  - FWFT=1:
//    - dout = mem[rptr] whenever !empty, and 0 when empty.
//    - A word written to an empty FIFO is visible on dout the cycle after its write edge.
//    - rd pops it: the next word appears after that edge.
//  - clr=1 at posedge:
//    - wptr=rptr=count=0; wr/rd ignored that cycle.
//    - No overflow/underflow pulse.
//    - dout unchanged when FWFT=0.
//  - rst_n asserted mid-operation: all state cleared immediately. No partial write or read is completed.
// TESTING
//  1. Reset, then write 0x01..0x10 (DEPTH=16).
//     -> full=1, count=16, almost_full high from count=14.
//     Then read 16 (FWFT=0) -> dout 0x01..0x10, each one cycle after its rd; then empty=1.
//  2. Full FIFO, wr=1 alone -> overflow pulses 1 cycle, count stays 16, data intact.
//     Empty FIFO, rd=1 -> underflow pulse, dout unchanged.
//  3. Full FIFO, wr=1 rd=1 din=0xAA -> count stays 16, no overflow.
//     Drain -> 0xAA emerges last.
//  4. Empty FIFO, wr=1 rd=1 din=0x55 -> underflow=1, count=1.
//     Next read -> 0x55.
//  5. FWFT=1: write 0x3C to empty -> dout=0x3C next cycle with no rd.
//     Pop -> empty=1, dout=0.
//  6. Wrap and flush:
//     - Write 12, read 10, write 10 (pointers wrap) -> count=12, order preserved.
//     - Assert clr -> count=0, empty=1.
//     - Async rst_n low mid-burst -> outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param.
// Producer/consumer side is master, FIFO side is slave.
interface sync_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int AW = $clog2(DEPTH);

   logic              clr;
   logic              wr;
   logic [DATA_W-1:0] din;
   logic              rd;
   logic [DATA_W-1:0] dout;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [AW:0]       count;
   logic              overflow;
   logic              underflow;

   modport master (
      output clr, wr, din, rd,
      input  dout, full, empty, almost_full,
      input  almost_empty, count, overflow, underflow
   );

   modport slave (
      input  clr, wr, din, rd,
      output dout, full, empty, almost_full,
      output almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level flags,
// flush, error pulses and optional fall-through read.
module sync_fifo_param #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 2,
   parameter int FWFT   = 0
) (
   input logic              clk,
   input logic              rst_n,
   sync_fifo_param_if.slave f
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              rd_ok, wr_ok, mem_we;
   logic              full_c, empty_c;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == DEPTH_C);

   assign f.full         = full_c;
   assign f.empty        = empty_c;
   assign f.almost_full  = (count_q >= AF_C);
   assign f.almost_empty = (count_q <= AE_C);
   assign f.count        = count_q;
   assign f.overflow     = ovf_q;
   assign f.underflow    = udf_q;

   // Fall-through shows the head word directly; else registered.
   if (FWFT != 0) begin : g_fwft
      assign f.dout = empty_c ? '0 : mem[rptr_q];
   end else begin : g_reg
      assign f.dout = dout_q;
   end

   // Accept decisions and next-state; flush overrides everything.
   always_comb begin
      rd_ok   = f.rd & ~empty_c;
      wr_ok   = f.wr & (~full_c | f.rd);
      mem_we  = 1'b0;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      dout_d  = dout_q;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      if (f.clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         mem_we = wr_ok;
         if (wr_ok)
            wptr_d = wptr_q + 1'b1;
         if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = mem[rptr_q];
         end
         count_d = count_q
                 + {{AW{1'b0}}, wr_ok}
                 - {{AW{1'b0}}, rd_ok};
         ovf_d = f.wr & ~wr_ok;
         udf_d = f.rd & ~rd_ok;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage array; contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wptr_q] <= f.din;
   end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param.
// Registered and fall-through instances share stimulus.
module tb_sync_fifo_param;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic wr    = 1'b0;
   logic rd    = 1'b0;
   logic clr   = 1'b0;
   logic [DW-1:0] din = '0;

   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) f0 ();
   sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) f1 ();

   assign f0.wr  = wr;
   assign f0.rd  = rd;
   assign f0.clr = clr;
   assign f0.din = din;
   assign f1.wr  = wr;
   assign f1.rd  = rd;
   assign f1.clr = clr;
   assign f1.din = din;

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .f(f0.slave));
   sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .f(f1.slave));

   int nerr = 0;
   int nchk = 0;
   logic [DW-1:0] q [$];
   logic [DW-1:0] exp_d0 = '0;
   bit ovf_e = 0;
   bit udf_e = 0;

   typedef struct {
      bit      w;
      bit      r;
      bit      c;
      logic [7:0] d;
      int      cnt;
      bit      ovf;
      bit      udf;
   } vec_t;
   vec_t tv [13];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count0", 32'(f0.count), n);
      chk("count1", 32'(f1.count), n);
      chk("full", 32'(f0.full), 32'(n == DEPTH));
      chk("empty", 32'(f0.empty), 32'(n == 0));
      chk("afull", 32'(f0.almost_full), 32'(n >= DEPTH - 2));
      chk("aempty", 32'(f0.almost_empty), 32'(n <= 2));
      chk("ovf", 32'(f0.overflow), 32'(ovf_e));
      chk("udf", 32'(f0.underflow), 32'(udf_e));
      chk("dout_reg", 32'(f0.dout), 32'(exp_d0));
      chk("dout_fwft", 32'(f1.dout), (n > 0) ? 32'(q[0]) : 32'd0);
   endtask

   task automatic cyc(bit w, bit r, bit c, logic [7:0] d);
      bit rok, wok;
      int n;
      wr  = w;
      rd  = r;
      clr = c;
      din = d;
      n   = q.size();
      rok = r && (n > 0);
      wok = w && ((n < DEPTH) || r);
      @(posedge clk);
      #1;
      if (c) begin
         q.delete();
         ovf_e = 0;
         udf_e = 0;
      end else begin
         if (rok)
            exp_d0 = q.pop_front();
         if (wok)
            q.push_back(d);
         ovf_e = w && !wok;
         udf_e = r && !rok;
      end
      wr  = 0;
      rd  = 0;
      clr = 0;
      check_all();
   endtask

   initial begin
      tv[0]  = '{1, 0, 0, 8'h11, 1, 0, 0};
      tv[1]  = '{1, 0, 0, 8'h22, 2, 0, 0};
      tv[2]  = '{1, 0, 0, 8'h33, 3, 0, 0};
      tv[3]  = '{1, 1, 0, 8'h44, 3, 0, 0};
      tv[4]  = '{0, 1, 0, 8'h00, 2, 0, 0};
      tv[5]  = '{0, 1, 0, 8'h00, 1, 0, 0};
      tv[6]  = '{0, 1, 0, 8'h00, 0, 0, 0};
      tv[7]  = '{0, 1, 0, 8'h00, 0, 0, 1};
      tv[8]  = '{1, 1, 0, 8'h55, 1, 0, 1};
      tv[9]  = '{0, 1, 0, 8'h00, 0, 0, 0};
      tv[10] = '{1, 0, 0, 8'h66, 1, 0, 0};
      tv[11] = '{1, 1, 1, 8'h77, 0, 0, 0};
      tv[12] = '{0, 1, 0, 8'h00, 0, 0, 1};

      // reset state
      #12;
      check_all();
      rst_n = 1'b1;

      foreach (tv[i]) begin
         cyc(tv[i].w, tv[i].r, tv[i].c, tv[i].d);
         chk($sformatf("vec%0d_cnt", i), 32'(f0.count), tv[i].cnt);
         chk($sformatf("vec%0d_ovf", i), 32'(f0.overflow), 32'(tv[i].ovf));
         chk($sformatf("vec%0d_udf", i), 32'(f0.underflow), 32'(tv[i].udf));
      end
      chk("vec_pop55", 32'(f0.dout), 32'h55);

      // fill to full
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1, 0, 0, 8'(i));
         chk("t1_af_edge", 32'(f0.almost_full), 32'(i >= 14));
      end
      chk("t1_full", 32'(f0.full), 1);
      chk("t1_cnt16", 32'(f0.count), 16);

      // overflow on full
      cyc(1, 0, 0, 8'hEE);
      chk("t2_ovf", 32'(f0.overflow), 1);
      chk("t2_cnt", 32'(f0.count), 16);
      cyc(0, 0, 0, 8'h00);
      chk("t2_ovf_gone", 32'(f0.overflow), 0);

      // simultaneous on full
      cyc(1, 1, 0, 8'hAA);
      chk("t3_noovf", 32'(f0.overflow), 0);
      chk("t3_cnt", 32'(f0.count), 16);
      chk("t3_first", 32'(f0.dout), 32'h01);
      for (int i = 0; i < DEPTH; i++)
         cyc(0, 1, 0, 8'h00);
      chk("t3_last", 32'(f0.dout), 32'hAA);
      chk("t3_empty", 32'(f0.empty), 1);

      // underflow keeps dout
      cyc(0, 1, 0, 8'h00);
      chk("t2_udf", 32'(f0.underflow), 1);
      chk("t2_hold", 32'(f0.dout), 32'hAA);

      // fall-through visibility
      cyc(1, 0, 0, 8'h3C);
      chk("t5_fwft", 32'(f1.dout), 32'h3C);
      cyc(0, 1, 0, 8'h00);
      chk("t5_pop_dout", 32'(f1.dout), 0);
      chk("t5_pop_empty", 32'(f1.empty), 1);

      // wrap
      for (int i = 0; i < 12; i++)
         cyc(1, 0, 0, 8'(8'h80 + i));
      for (int i = 0; i < 10; i++)
         cyc(0, 1, 0, 8'h00);
      for (int i = 0; i < 10; i++)
         cyc(1, 0, 0, 8'(8'hC0 + i));
      chk("t6_cnt12", 32'(f0.count), 12);
      cyc(0, 1, 0, 8'h00);
      chk("t6_order", 32'(f0.dout), 32'h8A);
      cyc(0, 1, 0, 8'h00);
      cyc(0, 1, 0, 8'h00);
      chk("t6_wrapped", 32'(f0.dout), 32'hC0);

      // flush
      cyc(0, 0, 1, 8'h00);
      chk("t6_clr_cnt", 32'(f0.count), 0);
      chk("t6_clr_empty", 32'(f0.empty), 1);
      chk("t6_clr_dout", 32'(f0.dout), 32'hC0);

      // async reset mid-burst
      for (int i = 0; i < 4; i++)
         cyc(1, 0, 0, 8'(8'h10 + i));
      cyc(0, 1, 0, 8'h00);
      wr  = 1;
      din = 8'h99;
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      exp_d0 = '0;
      ovf_e  = 0;
      udf_e  = 0;
      check_all();
      chk("t6_rst_cnt", 32'(f0.count), 0);
      chk("t6_rst_dout", 32'(f0.dout), 0);
      @(posedge clk);
      #1;
      wr = 0;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // sane after reset
      cyc(1, 0, 0, 8'h5A);
      cyc(0, 1, 0, 8'h00);
      chk("post_rst", 32'(f0.dout), 32'h5A);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
